// File: rtl/pwm_start_sequencer_if.sv
// Control-side bundle for pwm_start_sequencer: start/stop requests, packed
// per-channel delays, and the sequenced enables plus status flags.
interface pwm_start_sequencer_if #(
  parameter int unsigned N_CHANNELS    = 4,
  parameter int unsigned COUNTER_WIDTH = 16
);
  logic                                start;
  logic                                stop;
  logic [N_CHANNELS*COUNTER_WIDTH-1:0] delay;
  logic [N_CHANNELS-1:0]               channel_enable;
  logic                                busy;
  logic                                running;
  logic                                done;

  modport master (
    output start, stop, delay,
    input  channel_enable, busy, running, done
  );

  modport slave (
    input  start, stop, delay,
    output channel_enable, busy, running, done
  );
endinterface

// File: rtl/pwm_start_sequencer.sv
// Releases N PWM channel enables at latched offsets from one start request,
// using a single shared elapsed counter. Define PWM_SEQ_REVERSE_STOP_EN for
// staggered reverse-order shutdown from RUN; otherwise stop is immediate.
module pwm_start_sequencer #(
  parameter int unsigned N_CHANNELS    = 4,
  parameter int unsigned COUNTER_WIDTH = 16
) (
  input logic                 clock,
  input logic                 reset,
  pwm_start_sequencer_if.slave bus
);

  localparam int unsigned N = N_CHANNELS;
  localparam int unsigned W = COUNTER_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_SEQUENCE,
    ST_RUN
`ifdef PWM_SEQ_REVERSE_STOP_EN
    , ST_STOPPING
`endif
  } state_t;

  state_t         state;
  logic [W-1:0]   shadow [N];
  logic [W-1:0]   elapsed;
  logic [W-1:0]   max_delay;
  logic [N-1:0]   enable_q;
  logic           busy_q;
  logic           running_q;
  logic           done_q;

  logic [W-1:0]   delay_max;
  logic [N-1:0]   start_hit;
  logic           at_max;

  always_comb begin
    delay_max = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (bus.delay[i*W +: W] > delay_max) begin
        delay_max = bus.delay[i*W +: W];
      end
    end
  end

  always_comb begin
    start_hit = '0;
    for (int unsigned i = 0; i < N; i++) begin
      start_hit[i] = (elapsed == shadow[i]);
    end
  end

  assign at_max = (elapsed == max_delay);

`ifdef PWM_SEQ_REVERSE_STOP_EN
  logic [N-1:0] stop_hit;

  // Mirror of the start schedule: the largest offset is released first.
  always_comb begin
    stop_hit = '0;
    for (int unsigned i = 0; i < N; i++) begin
      stop_hit[i] = (elapsed == (max_delay - shadow[i]));
    end
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      elapsed   <= '0;
      max_delay <= '0;
      enable_q  <= '0;
      busy_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state  <= ST_ARM;
            busy_q <= 1'b1;
          end
        end

        ST_ARM: begin
          if (bus.stop) begin
            state    <= ST_IDLE;
            busy_q   <= 1'b0;
            enable_q <= '0;
          end else begin
            for (int unsigned i = 0; i < N; i++) begin
              shadow[i] <= bus.delay[i*W +: W];
            end
            max_delay <= delay_max;
            elapsed   <= '0;
            state     <= ST_SEQUENCE;
          end
        end

        ST_SEQUENCE: begin
          if (bus.stop) begin
            state    <= ST_IDLE;
            busy_q   <= 1'b0;
            enable_q <= '0;
          end else if (at_max) begin
            // Counter parks at max_delay, so a full-scale offset never wraps.
            enable_q  <= '1;
            done_q    <= 1'b1;
            running_q <= 1'b1;
            busy_q    <= 1'b0;
            state     <= ST_RUN;
          end else begin
            enable_q <= enable_q | start_hit;
            elapsed  <= elapsed + 1'b1;
          end
        end

        ST_RUN: begin
          if (bus.stop) begin
            running_q <= 1'b0;
`ifdef PWM_SEQ_REVERSE_STOP_EN
            state     <= ST_STOPPING;
            busy_q    <= 1'b1;
            elapsed   <= '0;
`else
            state     <= ST_IDLE;
            enable_q  <= '0;
`endif
          end
        end

`ifdef PWM_SEQ_REVERSE_STOP_EN
        ST_STOPPING: begin
          if (at_max) begin
            state    <= ST_IDLE;
            busy_q   <= 1'b0;
            enable_q <= '0;
          end else begin
            enable_q <= enable_q & ~stop_hit;
            elapsed  <= elapsed + 1'b1;
          end
        end
`endif

        default: begin
          state     <= ST_IDLE;
          enable_q  <= '0;
          busy_q    <= 1'b0;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.channel_enable = enable_q;
  assign bus.busy           = busy_q;
  assign bus.running        = running_q;
  assign bus.done           = done_q;

  a_run_all_enabled: assert property (@(posedge clock) disable iff (!reset)
    bus.running |-> (&bus.channel_enable));
  a_busy_run_exclusive: assert property (@(posedge clock) disable iff (!reset)
    !(bus.busy && bus.running));
  a_done_in_run: assert property (@(posedge clock) disable iff (!reset)
    bus.done |-> bus.running);

endmodule

// File: tb/tb_pwm_start_sequencer.sv
// Self-checking bench for pwm_start_sequencer: table-driven start sequences
// scored through an expectation queue, plus hand-written corner sequences.
module tb_pwm_start_sequencer;

  localparam int unsigned N = 4;
  localparam int unsigned W = 16;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [6:0] exp_q [$];

  typedef struct packed {
    logic [63:0] delays;
    logic [31:0] rise;
    logic        hold_start;
    logic [7:0]  zero_at;
  } vec_t;

  vec_t vecs [5];

  pwm_start_sequencer_if #(.N_CHANNELS(N), .COUNTER_WIDTH(W)) bus_if ();

  pwm_start_sequencer #(.N_CHANNELS(N), .COUNTER_WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [6:0] sample();
    return {bus_if.channel_enable, bus_if.busy, bus_if.running, bus_if.done};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, act, expv);
    end
  endtask

  // Start at edge 0; outputs {en[3:0],busy,running,done} scored per edge up to two past done.
  task automatic run_vec(input int idx, input logic [63:0] d, input logic [31:0] rise,
                         input logic hold, input int zero_at);
    int         de;
    logic [3:0] en;
    logic [6:0] x;
    de = 0;
    for (int i = 0; i < 4; i++) if (int'(rise[i*8 +: 8]) > de) de = int'(rise[i*8 +: 8]);
    for (int e = 0; e <= de + 2; e++) begin
      for (int i = 0; i < 4; i++) en[i] = (e >= int'(rise[i*8 +: 8]));
      exp_q.push_back({en, (e < de), (e >= de), (e == de)});
    end
    bus_if.delay = d;
    bus_if.start = 1'b1;
    tick();
    if (!hold) bus_if.start = 1'b0;
    for (int e = 0; e <= de + 2; e++) begin
      if (e == zero_at) bus_if.delay = '0;
      if (exp_q.size() == 0) begin
        check($sformatf("vec%0d_queue_empty_e%0d", idx, e), 32'd0, 32'd1);
      end else begin
        x = exp_q.pop_front();
        check($sformatf("vec%0d_e%0d", idx, e), 32'(sample()), 32'(x));
      end
      if (e < de + 2) tick();
    end
    bus_if.start = 1'b0;
  endtask

  task automatic stop_from_run(input logic [63:0] d);
`ifdef PWM_SEQ_REVERSE_STOP_EN
    int         mx;
    logic [3:0] en;
    mx = 0;
    for (int i = 0; i < 4; i++) if (int'(d[i*16 +: 16]) > mx) mx = int'(d[i*16 +: 16]);
    for (int k = 0; k <= mx; k++) begin
      for (int i = 0; i < 4; i++) en[i] = !((mx - int'(d[i*16 +: 16])) <= k);
      exp_q.push_back({en, (k < mx), 1'b0, 1'b0});
    end
    bus_if.stop = 1'b1;
    tick();
    bus_if.stop = 1'b0;
    check("stopping_entry", 32'(sample()), 32'({4'hF, 1'b1, 1'b0, 1'b0}));
    bus_if.start = 1'b1;
    for (int k = 0; k <= mx; k++) begin
      tick();
      check($sformatf("stopping_k%0d", k), 32'(sample()), 32'(exp_q.pop_front()));
    end
    bus_if.start = 1'b0;
`else
    bus_if.stop = 1'b1;
    tick();
    bus_if.stop = 1'b0;
    check($sformatf("stop_run_%0h", d[15:0]), 32'(sample()), 32'd0);
`endif
    tick();
    check("idle_after_stop", 32'(sample()), 32'd0);
  endtask

  initial begin
    int e;

    vecs[0] = '{delays: {16'd10, 16'd3, 16'd3, 16'd0},  rise: {8'd12, 8'd5, 8'd5, 8'd2},
                hold_start: 1'b0, zero_at: 8'hFF};
    vecs[1] = '{delays: {16'd0, 16'd0, 16'd0, 16'd0},   rise: {8'd2, 8'd2, 8'd2, 8'd2},
                hold_start: 1'b0, zero_at: 8'hFF};
    vecs[2] = '{delays: {16'd16, 16'd12, 16'd8, 16'd4}, rise: {8'd18, 8'd14, 8'd10, 8'd6},
                hold_start: 1'b1, zero_at: 8'd2};
    vecs[3] = '{delays: {16'd9, 16'd6, 16'd3, 16'd0},   rise: {8'd11, 8'd8, 8'd5, 8'd2},
                hold_start: 1'b0, zero_at: 8'hFF};
    vecs[4] = '{delays: {16'd7, 16'd1, 16'd0, 16'd7},   rise: {8'd9, 8'd3, 8'd2, 8'd9},
                hold_start: 1'b0, zero_at: 8'hFF};

    reset        = 1'b0;
    bus_if.start = 1'b0;
    bus_if.stop  = 1'b0;
    bus_if.delay = '0;
    #8;
    check("reset_state", 32'(sample()), 32'd0);
    #4;
    reset = 1'b1;
    tick();
    check("idle_after_reset", 32'(sample()), 32'd0);

    for (int v = 0; v < 5; v++) begin
      run_vec(v, vecs[v].delays, vecs[v].rise, vecs[v].hold_start, int'(vecs[v].zero_at));
      stop_from_run(vecs[v].delays);
    end

    // Abort mid-sequence: delays {5,20,40,60}, stop sampled on edge 26.
    bus_if.delay = {16'd60, 16'd40, 16'd20, 16'd5};
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      check($sformatf("abort_e%0d", k), 32'(sample()),
            32'({1'b0, 1'b0, (k >= 22), (k >= 7), 1'b1, 1'b0, 1'b0}));
    end
    bus_if.stop = 1'b1;
    tick();
    bus_if.stop = 1'b0;
    check("abort_cleared", 32'(sample()), 32'd0);
    for (int k = 27; k <= 66; k++) begin
      tick();
      check($sformatf("abort_idle_e%0d", k), 32'(sample()), 32'd0);
    end

    // Stop coincident with the final sequence cycle: stop wins, no done.
    bus_if.delay = {16'd3, 16'd3, 16'd3, 16'd3};
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    repeat (4) tick();
    check("finalstop_e4", 32'(sample()), 32'({4'h0, 1'b1, 1'b0, 1'b0}));
    bus_if.stop = 1'b1;
    tick();
    bus_if.stop = 1'b0;
    check("finalstop_e5", 32'(sample()), 32'd0);
    tick();
    check("finalstop_e6", 32'(sample()), 32'd0);

    // Start and stop together in IDLE: start wins.
    bus_if.delay = {16'd1, 16'd1, 16'd1, 16'd1};
    bus_if.start = 1'b1;
    bus_if.stop  = 1'b1;
    tick();
    bus_if.start = 1'b0;
    bus_if.stop  = 1'b0;
    check("startstop_arm", 32'(sample()), 32'({4'h0, 1'b1, 1'b0, 1'b0}));
    repeat (3) tick();
    check("startstop_run", 32'(sample()), 32'({4'hF, 1'b0, 1'b1, 1'b1}));
    stop_from_run({16'd1, 16'd1, 16'd1, 16'd1});

    // Async reset mid-sequence, then a clean restart.
    bus_if.delay = {16'd10, 16'd10, 16'd1, 16'd0};
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    repeat (5) tick();
    check("midreset_before", 32'(sample()), 32'({4'b0011, 1'b1, 1'b0, 1'b0}));
    reset = 1'b0;
    #2;
    check("midreset_async", 32'(sample()), 32'd0);
    #1;
    reset = 1'b1;
    run_vec(10, {16'd4, 16'd3, 16'd2, 16'd1}, {8'd6, 8'd5, 8'd4, 8'd3}, 1'b0, -1);
    stop_from_run({16'd4, 16'd3, 16'd2, 16'd1});

    // Full-scale offset on channel 0: rises 2^16+1 edges after start.
    bus_if.delay = {16'd0, 16'd0, 16'd0, 16'hFFFF};
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    e = 0;
    while (bus_if.channel_enable[0] == 1'b0 && e < 70000) begin
      tick();
      e++;
      if (e == 2) check("maxdelay_e2", 32'(sample()), 32'({4'b1110, 1'b1, 1'b0, 1'b0}));
    end
    check("maxdelay_rise_edge", 32'(e), 32'd65537);
    check("maxdelay_done", 32'(sample()), 32'({4'hF, 1'b0, 1'b1, 1'b1}));
    reset = 1'b0;
    #2;
    check("maxdelay_reset", 32'(sample()), 32'd0);
    #1;
    reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
